mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single-port zero-delay RAM between the RV32I fetch port and the load/store port.
// - Arbitrates round-robin, aligns sub-word loads and sign/zero-extends them.
// - Builds byte and halfword stores as two-cycle read-modify-write, because the RAM holds whole words only.
// - Sits between the core (fetch and LSU) and the RAM; its RAM-side ports connect straight to the RAM.
// PARAMETERS
// - dataW        32  data width; fixed at 32 for RV32I.
// - RAMAddrSize  32  byte-address width toward the core and the RAM.
// PORTS
// clock        in   1            single clock, all state on posedge
// nReset       in   1            asynchronous reset, active low
// ifReq        in   1            fetch request; holds ifAddr stable until ifGnt
// ifAddr       in   RAMAddrSize  fetch byte address
// ifGnt        out  1            fetch accepted this cycle (combinational)
// ifRspValid   out  1            fetch response valid, one cycle after ifGnt
// ifRspData    out  dataW        fetched word
// ifErr        out  1            with ifRspValid: misaligned fetch
// dReq         in   1            data request; holds all d* inputs stable until dGnt
// dWrite       in   1            1 = store, 0 = load
// dSize        in   2            00 byte, 01 half, 10 word, 11 illegal
// dUnsigned    in   1            loads only: zero-extend (LBU/LHU)
// dAddr        in   RAMAddrSize  data byte address
// dWData       in   dataW        store data, right-justified
// dGnt         out  1            data request accepted this cycle (combinational)
// dRspValid    out  1            data response valid (loads and stores)
// dRspData     out  dataW        extended load data; 0 for stores and errors
// dErr         out  1            with dRspValid: misaligned or illegal size
// RAMAddr      out  RAMAddrSize  word-aligned address {addr[31:2],2'b00}
// RAMDataIn    out  dataW        write word
// RAMWriteCtl  out  1            RAM write enable
// RAMDataOut   in   dataW        RAM read word (combinational from RAMAddr)
// BEHAVIOUR
// - Reset: every output 0; FSM goes to IDLE; lastGnt = FETCH, so the first contention goes to data.
// - FSM states:
//   - IDLE: may grant. Any request except a legal sub-word store completes in the grant cycle; stay in IDLE.
//   - RMW_WR: entered after a sub-word store is granted. Drives the merged write for exactly one cycle, then returns to IDLE.
//   - No grants are given while in RMW_WR.
// - Arbitration in IDLE:
//   - Only one requester: grant it.
//   - Both requesting: grant the one not in lastGnt.
//   - lastGnt updates on every grant.
//   - At most one gnt per cycle; back-to-back grants are allowed.
// - Fetch or load grant cycle:
//   - RAMAddr is the aligned address and RAMWriteCtl = 0.
//   - The lane is extracted and extended at the edge; rsp is registered, so latency is 1.
//   - Byte lane = addr[1:0]; half lane = addr[1].
//   - Sign-extend unless dUnsigned is set.
// - Word store: RAMWriteCtl = 1 in the grant cycle with RAMDataIn = dWData; dRspValid on the next cycle.
// - Sub-word store:
//   - Grant cycle: RAM read only; the merged word (old word with the target lane replaced) is registered.
//   - RMW_WR cycle: RAMWriteCtl = 1 with the merged word.
//   - dRspValid on the cycle after RMW_WR, so latency is 2.
// - Misalignment: half with addr[0]=1, word with addr[1:0]≠0, or dSize = 11.
//   - The request is granted, but the RAM is not accessed (RAMWriteCtl = 0).
//   - Err and RspValid are asserted next cycle with data 0.
//   - Fetch is misaligned when ifAddr[1:0]≠0.
// - Response pulses:
//   - RspValid is a one-cycle pulse per granted request; there is no backpressure.
//   - Responses stay in request order per port.
// - Idle bus: when nothing is granted and the FSM is in IDLE, RAMWriteCtl = 0 and RAMAddr holds its last value.
// - Reset mid-RMW: the pending write is dropped, no response is issued, and the FSM returns to IDLE.
// - The RAM protects its own I/O words (0x0–0xF); this block does not special-case them.
// STRUCTURE
// - Package mem_arb_pkg holds:
//   - typedef enum {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL} mem_size_t
//   - typedef enum {IDLE, RMW_WR} arb_state_t
//   - typedef enum {GNT_FETCH, GNT_DATA} gnt_t
// - Sub-module mem_lane_align (combinational) does lane extract with sign/zero-extend, lane merge for stores, and the misalign check.
// TESTING
// - Word load: RAM[0x100]=0xDEADBEEF, dReq load word @0x100 -> dGnt same cycle; next cycle dRspValid=1, dRspData=0xDEADBEEF.
// - Byte loads: @0x101 signed -> 0xFFFFFFBE; same address with dUnsigned=1 -> 0x000000BE; half @0x102 signed -> 0xFFFFDEAD.
// - Byte store: SB 0x55 @0x103 over 0xDEADBEEF -> RAMWriteCtl low in cycle 0 and high in cycle 1 with 0x55ADBEEF; dRspValid in cycle 2.
// - Contention: ifReq and dReq held high together for 4 cycles after reset -> grants D,F,D,F; no cycle has both gnts.
// - RMW blocking: ifReq asserted during RMW_WR -> ifGnt stays 0 that cycle and rises the next.
// - Misaligned and reset: LW @0x102 -> dErr=1, dRspData=0, no RAM write. nReset pulsed low during RMW_WR -> RAM word unchanged, no dRspValid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Size encoding matches the dSize field driven by the load/store unit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_t;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side fetch/data handshakes plus the RAM-side bus of the arbiter.
// slave is the arbiter's view; master is the core and RAM environment.
interface mem_port_arbiter_if #(
    parameter int unsigned dataW       = 32,
    parameter int unsigned RAMAddrSize = 32
);
    logic                   ifReq;
    logic [RAMAddrSize-1:0] ifAddr;
    logic                   ifGnt;
    logic                   ifRspValid;
    logic [dataW-1:0]       ifRspData;
    logic                   ifErr;

    logic                   dReq;
    logic                   dWrite;
    logic [1:0]             dSize;
    logic                   dUnsigned;
    logic [RAMAddrSize-1:0] dAddr;
    logic [dataW-1:0]       dWData;
    logic                   dGnt;
    logic                   dRspValid;
    logic [dataW-1:0]       dRspData;
    logic                   dErr;

    logic [RAMAddrSize-1:0] RAMAddr;
    logic [dataW-1:0]       RAMDataIn;
    logic                   RAMWriteCtl;
    logic [dataW-1:0]       RAMDataOut;

    modport slave (
        input  ifReq, ifAddr, dReq, dWrite, dSize, dUnsigned, dAddr, dWData, RAMDataOut,
        output ifGnt, ifRspValid, ifRspData, ifErr, dGnt, dRspValid, dRspData, dErr,
        output RAMAddr, RAMDataIn, RAMWriteCtl
    );

    modport master (
        output ifReq, ifAddr, dReq, dWrite, dSize, dUnsigned, dAddr, dWData, RAMDataOut,
        input  ifGnt, ifRspValid, ifRspData, ifErr, dGnt, dRspValid, dRspData, dErr,
        input  RAMAddr, RAMDataIn, RAMWriteCtl
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: sub-word extract with sign/zero extension,
// store lane merge into the old word, and the alignment check.
module mem_lane_align
    import mem_arb_pkg::*;
#(
    parameter int unsigned dataW = 32
) (
    input  mem_size_t        size,
    input  logic             is_unsigned,
    input  logic [1:0]       addr_lo,
    input  logic [dataW-1:0] rdata,
    input  logic [dataW-1:0] wdata,
    output logic [dataW-1:0] load_data,
    output logic [dataW-1:0] merged,
    output logic             misaligned
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = rdata[{addr_lo, 3'b000} +: 8];
        half_v     = rdata[{addr_lo[1], 4'b0000} +: 16];
        misaligned = 1'b0;
        load_data  = rdata;
        merged     = rdata;
        unique case (size)
            SZ_BYTE: begin
                load_data = {{(dataW-8){~is_unsigned & byte_v[7]}}, byte_v};
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                misaligned = addr_lo[0];
                load_data  = {{(dataW-16){~is_unsigned & half_v[15]}}, half_v};
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_WORD: misaligned = |addr_lo;
            SZ_ILL:  misaligned = 1'b1;
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word-wide zero-delay RAM between fetch and
// load/store; sub-word stores become a read then a merged write.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned dataW       = 32,
    parameter int unsigned RAMAddrSize = 32
) (
    input logic               clock,
    input logic               nReset,
    mem_port_arbiter_if.slave bus
);
    arb_state_t             state_q, state_d;
    gnt_t                   last_gnt_q, last_gnt_d;
    logic [RAMAddrSize-1:0] addr_q;
    logic [RAMAddrSize-1:0] ram_addr;
    logic [dataW-1:0]       ram_wdata;
    logic                   ram_we;
    logic [dataW-1:0]       merged_q;
    logic                   if_gnt, d_gnt, d_rmw;
    logic                   if_misaligned, d_misaligned;
    logic [dataW-1:0]       d_load_data, d_merged;
    mem_size_t              d_size;

    logic                   if_rsp_valid_q, if_err_q;
    logic [dataW-1:0]       if_rsp_data_q;
    logic                   d_rsp_valid_q, d_err_q;
    logic [dataW-1:0]       d_rsp_data_q;

    assign d_size        = mem_size_t'(bus.dSize);
    assign if_misaligned = |bus.ifAddr[1:0];

    mem_lane_align #(
        .dataW(dataW)
    ) u_align (
        .size       (d_size),
        .is_unsigned(bus.dUnsigned),
        .addr_lo    (bus.dAddr[1:0]),
        .rdata      (bus.RAMDataOut),
        .wdata      (bus.dWData),
        .load_data  (d_load_data),
        .merged     (d_merged),
        .misaligned (d_misaligned)
    );

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        d_rmw      = 1'b0;
        ram_addr   = addr_q;
        ram_wdata  = '0;
        ram_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ifReq && bus.dReq) begin
                    d_gnt  = (last_gnt_q == GNT_FETCH);
                    if_gnt = ~d_gnt;
                end else begin
                    if_gnt = bus.ifReq;
                    d_gnt  = bus.dReq;
                end
                if (d_gnt) begin
                    last_gnt_d = GNT_DATA;
                    // Misaligned or illegal requests leave the RAM bus untouched.
                    if (!d_misaligned) begin
                        ram_addr = {bus.dAddr[RAMAddrSize-1:2], 2'b00};
                        if (bus.dWrite) begin
                            if (d_size == SZ_WORD) begin
                                ram_we    = 1'b1;
                                ram_wdata = bus.dWData;
                            end else begin
                                d_rmw   = 1'b1;
                                state_d = RMW_WR;
                            end
                        end
                    end
                end else if (if_gnt) begin
                    last_gnt_d = GNT_FETCH;
                    if (!if_misaligned) begin
                        ram_addr = {bus.ifAddr[RAMAddrSize-1:2], 2'b00};
                    end
                end
            end
            RMW_WR: begin
                ram_we    = 1'b1;
                ram_wdata = merged_q;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            last_gnt_q <= GNT_FETCH;
            addr_q     <= '0;
            merged_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            // addr_q doubles as the RMW write address, held from the read cycle.
            addr_q     <= ram_addr;
            if (d_rmw) begin
                merged_q <= d_merged;
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            if_err_q       <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_data_q   <= '0;
            d_err_q        <= 1'b0;
        end else begin
            if_rsp_valid_q <= if_gnt;
            if_rsp_data_q  <= (if_gnt && !if_misaligned) ? bus.RAMDataOut : '0;
            if_err_q       <= if_gnt && if_misaligned;
            d_rsp_valid_q  <= (d_gnt && !d_rmw) || (state_q == RMW_WR);
            d_rsp_data_q   <= (d_gnt && !bus.dWrite && !d_misaligned) ? d_load_data : '0;
            d_err_q        <= d_gnt && d_misaligned;
        end
    end

    assign bus.ifGnt       = if_gnt;
    assign bus.dGnt        = d_gnt;
    assign bus.ifRspValid  = if_rsp_valid_q;
    assign bus.ifRspData   = if_rsp_data_q;
    assign bus.ifErr       = if_err_q;
    assign bus.dRspValid   = d_rsp_valid_q;
    assign bus.dRspData    = d_rsp_data_q;
    assign bus.dErr        = d_err_q;
    assign bus.RAMAddr     = ram_addr;
    assign bus.RAMDataIn   = ram_wdata;
    assign bus.RAMWriteCtl = ram_we;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases then random traffic, checked
// against a shadow-memory model with expected-response queues.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clock = 1'b0;
    logic nReset = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clock (clock),
        .nReset(nReset),
        .bus   (bus)
    );

    logic [31:0] ram [1024];
    assign bus.RAMDataOut = ram[bus.RAMAddr[11:2]];
    always @(posedge clock) begin
        if (bus.RAMWriteCtl) ram[bus.RAMAddr[11:2]] <= bus.RAMDataIn;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] ref_mem [1024];
    rsp_t        dq[$];
    rsp_t        fq[$];
    bit          busy, last_d, rnd_mode, keep_both;
    logic [31:0] rmw_addr;

    bit          p_if, p_d, d_write, d_uns;
    logic [1:0]  d_size;
    logic [31:0] if_addr, d_addr, d_wdata;

    logic [31:0] last_d_data, last_wdata;
    logic        last_d_err;
    logic [3:0]  gnt_hist;
    bit          both_seen;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit misaligned(logic [1:0] size, logic [1:0] off);
        return size == 2'd3 || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
    endfunction

    function automatic logic [31:0] ext_load(logic [31:0] w, logic [1:0] size, bit uns,
                                             logic [1:0] off);
        logic [31:0] v;
        v = w >> (8 * off);
        if (size == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_merge(logic [31:0] w, logic [31:0] wd,
                                                logic [1:0] size, logic [1:0] off);
        logic [31:0] mask;
        mask = (size == 2'd0) ? 32'hFF : 32'hFFFF;
        return (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
    endfunction

    task automatic gen_random();
        if (!p_if && $urandom_range(0, 3) != 0) begin
            p_if    = 1'b1;
            if_addr = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            if ($urandom_range(0, 7) == 0) if_addr[1:0] = 2'($urandom_range(1, 3));
        end
        if (!p_d && $urandom_range(0, 3) != 0) begin
            p_d     = 1'b1;
            d_write = 1'($urandom_range(0, 1));
            d_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            d_uns   = 1'($urandom_range(0, 1));
            d_addr  = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) begin
                if (d_size == 2'd2) d_addr[1:0] = 2'b00;
                if (d_size == 2'd1) d_addr[0] = 1'b0;
            end
            d_wdata = $urandom;
        end
    endtask

    // One clock of traffic: drive, check responses and grants, advance the model.
    task automatic step();
        bit          eg_if, eg_d, exp_we, bad;
        logic [31:0] exp_waddr, exp_wdata;
        int          idx;
        @(negedge clock);
        bus.ifReq     = p_if;
        bus.ifAddr    = if_addr;
        bus.dReq      = p_d;
        bus.dWrite    = d_write;
        bus.dSize     = d_size;
        bus.dUnsigned = d_uns;
        bus.dAddr     = d_addr;
        bus.dWData    = d_wdata;
        #1;
        if (dq.size() > 0 && dq[0].due == cyc) begin
            check_eq("d_rsp_valid", 32'(bus.dRspValid), 32'd1);
            check_eq("d_rsp_data", bus.dRspData, dq[0].data);
            check_eq("d_err", 32'(bus.dErr), 32'(dq[0].err));
            dq.delete(0);
        end else begin
            check_eq("d_rsp_valid", 32'(bus.dRspValid), 32'd0);
        end
        if (fq.size() > 0 && fq[0].due == cyc) begin
            check_eq("if_rsp_valid", 32'(bus.ifRspValid), 32'd1);
            check_eq("if_rsp_data", bus.ifRspData, fq[0].data);
            check_eq("if_err", 32'(bus.ifErr), 32'(fq[0].err));
            fq.delete(0);
        end else begin
            check_eq("if_rsp_valid", 32'(bus.ifRspValid), 32'd0);
        end
        if (bus.dRspValid) begin
            last_d_data = bus.dRspData;
            last_d_err  = bus.dErr;
        end

        eg_if = 1'b0; eg_d = 1'b0; exp_we = 1'b0;
        exp_waddr = '0; exp_wdata = '0;
        if (busy) begin
            busy      = 1'b0;
            exp_we    = 1'b1;
            exp_waddr = rmw_addr;
            exp_wdata = ref_mem[rmw_addr[11:2]];
        end else if (p_if && p_d) begin
            eg_d  = !last_d;
            eg_if = last_d;
        end else begin
            eg_if = p_if;
            eg_d  = p_d;
        end

        if (eg_if) begin
            last_d = 1'b0;
            if (if_addr[1:0] != 2'b00) fq.push_back('{cyc + 1, 32'd0, 1'b1});
            else fq.push_back('{cyc + 1, ref_mem[if_addr[11:2]], 1'b0});
        end
        if (eg_d) begin
            last_d = 1'b1;
            idx    = int'(d_addr[11:2]);
            bad    = misaligned(d_size, d_addr[1:0]);
            if (bad) begin
                dq.push_back('{cyc + 1, 32'd0, 1'b1});
            end else if (!d_write) begin
                dq.push_back('{cyc + 1, ext_load(ref_mem[idx], d_size, d_uns, d_addr[1:0]), 1'b0});
            end else if (d_size == 2'd2) begin
                exp_we       = 1'b1;
                exp_waddr    = {d_addr[31:2], 2'b00};
                exp_wdata    = d_wdata;
                ref_mem[idx] = d_wdata;
                dq.push_back('{cyc + 1, 32'd0, 1'b0});
            end else begin
                ref_mem[idx] = store_merge(ref_mem[idx], d_wdata, d_size, d_addr[1:0]);
                busy         = 1'b1;
                rmw_addr     = {d_addr[31:2], 2'b00};
                dq.push_back('{cyc + 2, 32'd0, 1'b0});
            end
        end

        check_eq("if_gnt", 32'(bus.ifGnt), 32'(eg_if));
        check_eq("d_gnt", 32'(bus.dGnt), 32'(eg_d));
        check_eq("ram_we", 32'(bus.RAMWriteCtl), 32'(exp_we));
        if (exp_we) begin
            check_eq("ram_waddr", bus.RAMAddr, exp_waddr);
            check_eq("ram_wdata", bus.RAMDataIn, exp_wdata);
        end
        if (bus.RAMWriteCtl) last_wdata = bus.RAMDataIn;
        gnt_hist  = {gnt_hist[2:0], bus.dGnt};
        both_seen = both_seen | (bus.ifGnt & bus.dGnt);

        if (eg_if && !keep_both) p_if = 1'b0;
        if (eg_d && !keep_both) p_d = 1'b0;
        if (rnd_mode) gen_random();
        cyc++;
    endtask

    task automatic run_quiet();
        int n;
        n = 0;
        while ((p_if || p_d || busy || dq.size() > 0 || fq.size() > 0) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check_eq("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue_d(bit wr, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd);
        p_d = 1'b1; d_write = wr; d_size = sz; d_uns = uns; d_addr = a; d_wdata = wd;
    endtask

    initial begin
        logic [31:0] v, saved;
        int          diffs;
        p_if = 0; p_d = 0; d_write = 0; d_uns = 0; d_size = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        busy = 0; last_d = 0; rnd_mode = 0; keep_both = 0; rmw_addr = 0;
        gnt_hist = 0; both_seen = 0; last_d_data = 0; last_d_err = 0; last_wdata = 0;
        bus.ifReq = 0; bus.ifAddr = 0; bus.dReq = 0; bus.dWrite = 0; bus.dSize = 0;
        bus.dUnsigned = 0; bus.dAddr = 0; bus.dWData = 0;
        for (int i = 0; i < 1024; i++) begin
            v          = $urandom;
            ram[i]     <= v;
            ref_mem[i] = v;
        end
        repeat (2) @(negedge clock);
        #1;
        check_eq("rst_if_gnt", 32'(bus.ifGnt), 32'd0);
        check_eq("rst_d_gnt", 32'(bus.dGnt), 32'd0);
        check_eq("rst_if_rsp", 32'(bus.ifRspValid), 32'd0);
        check_eq("rst_d_rsp", 32'(bus.dRspValid), 32'd0);
        check_eq("rst_we", 32'(bus.RAMWriteCtl), 32'd0);
        check_eq("rst_addr", bus.RAMAddr, 32'd0);
        check_eq("rst_wdata", bus.RAMDataIn, 32'd0);
        @(negedge clock);
        nReset = 1'b1;

        // Contention straight after reset: data wins first, then alternate.
        keep_both = 1; p_if = 1; if_addr = 32'h200;
        issue_d(0, 2'd2, 0, 32'h104, 0);
        repeat (4) step();
        check_eq("contend_seq", 32'(gnt_hist), 32'b1010);
        check_eq("contend_both", 32'(both_seen), 32'd0);
        keep_both = 0; p_if = 0; p_d = 0;
        run_quiet();

        issue_d(1, 2'd2, 0, 32'h100, 32'hDEAD_BEEF); run_quiet();
        issue_d(0, 2'd2, 0, 32'h100, 0); run_quiet();
        check_eq("lw", last_d_data, 32'hDEAD_BEEF);
        issue_d(0, 2'd0, 0, 32'h101, 0); run_quiet();
        check_eq("lb", last_d_data, 32'hFFFF_FFBE);
        issue_d(0, 2'd0, 1, 32'h101, 0); run_quiet();
        check_eq("lbu", last_d_data, 32'h0000_00BE);
        issue_d(0, 2'd1, 0, 32'h102, 0); run_quiet();
        check_eq("lh", last_d_data, 32'hFFFF_DEAD);

        // Byte store with a fetch arriving during the write cycle.
        issue_d(1, 2'd0, 0, 32'h103, 32'h0000_0055);
        step();
        p_if = 1; if_addr = 32'h300;
        step();
        step();
        run_quiet();
        check_eq("sb_wdata", last_wdata, 32'h55AD_BEEF);
        issue_d(0, 2'd2, 0, 32'h100, 0); run_quiet();
        check_eq("sb_readback", last_d_data, 32'h55AD_BEEF);

        issue_d(0, 2'd2, 0, 32'h102, 0); run_quiet();
        check_eq("lw_mis_err", 32'(last_d_err), 32'd1);
        check_eq("lw_mis_data", last_d_data, 32'd0);

        rnd_mode = 1;
        repeat (600) step();
        rnd_mode = 0;
        run_quiet();

        // Reset during the write cycle drops the store and its response.
        issue_d(1, 2'd0, 0, 32'h100, 32'h0000_00AA);
        saved = ref_mem[32'h100 >> 2];
        step();
        ref_mem[32'h100 >> 2] = saved;
        dq.delete();
        busy = 0;
        @(negedge clock);
        nReset = 1'b0; p_d = 0; bus.dReq = 0;
        #1;
        check_eq("rst_rmw_we", 32'(bus.RAMWriteCtl), 32'd0);
        @(negedge clock);
        nReset = 1'b1; last_d = 0;
        check_eq("rst_rmw_rsp", 32'(bus.dRspValid), 32'd0);
        step(); step();
        check_eq("rst_rmw_ram", ram[32'h100 >> 2], saved);
        issue_d(0, 2'd2, 0, 32'h100, 0); run_quiet();
        check_eq("rst_rmw_load", last_d_data, saved);

        diffs = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) diffs++;
        check_eq("ram_final", 32'(diffs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
